// File: rtl/pkg_uart.sv
// pkg_uart: shared UART constants and the TX FIFO controller state encoding.
package pkg_uart;

  localparam int unsigned CLOCKS_PER_BIT = 868;
  localparam int unsigned TX_FIFO_DEPTH  = 16;
  localparam int unsigned BYTE_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACTIVE,
    WAIT_DONE,
    COOLDOWN
  } txf_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock byte FIFO; occupancy flags derived from wrap-bit pointers.
module uart_sync_fifo
  import pkg_uart::*;
#(
  parameter int unsigned DEPTH = TX_FIFO_DEPTH,
  parameter int unsigned WIDTH = BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A pop on an empty FIFO is ignored; a push while full is only taken if a pop frees the slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; index bits wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Data storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter, launching exactly one frame per queued byte.
module uart_tx_fifo
  import pkg_uart::*;
#(
  parameter int unsigned DEPTH = TX_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [BYTE_W-1:0]      wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   tx_dv,
  output logic [BYTE_W-1:0]      tx_byte,
  input  logic                   tx_active,
  input  logic                   tx_done
);

  txf_state_e        state;
  logic              pop;
  logic [BYTE_W-1:0] head;

  // The head byte leaves the FIFO on the edge that ends the LAUNCH cycle.
  assign pop = (state == LAUNCH);

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sticky record of any byte dropped because no slot was available.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Launch sequencer: one tx_dv pulse per byte, then wait out the whole frame handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx_dv   <= 1'b0;
      tx_byte <= '0;
    end else begin
      tx_dv <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty && !tx_active) state <= LAUNCH;
        end
        LAUNCH: begin
          tx_dv   <= 1'b1;
          tx_byte <= head;
          state   <= WAIT_ACTIVE;
        end
        WAIT_ACTIVE: begin
          if (tx_active) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) state <= COOLDOWN;
        end
        COOLDOWN: begin
          if (!tx_done && !tx_active) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of the UART TX FIFO with a small serial transmitter model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int CPB = 4;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       wr_en     = 1'b0;
  logic [7:0] wr_data   = 8'h00;
  logic       hold_busy = 1'b0;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  // Transmitter model: start bit, 8 data bits LSB first, stop bit, then tx_done for 2 cycles.
  logic       m_active;
  logic [9:0] frame;
  int         bit_idx;
  int         clk_cnt;
  int         done_cnt;
  logic       serial;

  assign tx_active = hold_busy | m_active;
  assign tx_done   = (done_cnt != 0);
  assign serial    = m_active ? frame[bit_idx] : 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      frame    <= '1;
      bit_idx  <= 0;
      clk_cnt  <= 0;
      done_cnt <= 0;
    end else if (m_active) begin
      if (clk_cnt == CPB - 1) begin
        clk_cnt <= 0;
        if (bit_idx == 9) begin
          m_active <= 1'b0;
          done_cnt <= 2;
        end else begin
          bit_idx <= bit_idx + 1;
        end
      end else begin
        clk_cnt <= clk_cnt + 1;
      end
    end else if (done_cnt != 0) begin
      done_cnt <= done_cnt - 1;
    end else if (tx_dv) begin
      m_active <= 1'b1;
      frame    <= {1'b1, tx_byte, 1'b0};
      bit_idx  <= 0;
      clk_cnt  <= 0;
    end
  end

  // Monitor: decodes the serial line and audits tx_dv pulses.
  logic [7:0] rx_q[$];
  logic [9:0] rx_frame_q[$];
  logic [9:0] rbits;
  logic       rxing     = 1'b0;
  logic       prev_dv   = 1'b0;
  logic       have_prev = 1'b0;
  logic       done_seen = 1'b0;
  int         rcnt      = 0;
  int         dv_count  = 0;
  int         order_err = 0;
  int         wide_err  = 0;

  always @(negedge clk) begin
    if (rst) begin
      rxing     = 1'b0;
      prev_dv   = 1'b0;
      have_prev = 1'b0;
      done_seen = 1'b0;
    end else begin
      if (tx_done) done_seen = 1'b1;
      if (tx_dv) begin
        dv_count++;
        if (prev_dv) wide_err++;
        if (have_prev && !done_seen) order_err++;
        have_prev = 1'b1;
        done_seen = 1'b0;
      end
      prev_dv = tx_dv;
      if (!rxing && !serial) begin
        rxing = 1'b1;
        rcnt  = 0;
      end
      if (rxing) begin
        if (rcnt % CPB == CPB / 2) rbits[rcnt / CPB] = serial;
        if (rcnt == 9 * CPB + CPB / 2) begin
          rxing = 1'b0;
          rx_q.push_back(rbits[8:1]);
          rx_frame_q.push_back(rbits);
        end else begin
          rcnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return 32'(rx_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] frame_at(input int i);
    if (i < rx_frame_q.size()) return 32'(rx_frame_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  int base;
  int dvb;
  int mx;
  int nw;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_dv", 32'(tx_dv), 32'd0);
    check("rst_byte", 32'(tx_byte), 32'd0);

    // Single byte A5: latency, held byte, serial frame
    base = rx_q.size();
    dvb  = dv_count;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk); wr_en = 1'b0;
    check("a5_cnt1", 32'(count), 32'd1);
    check("a5_dv_e0", 32'(tx_dv), 32'd0);
    @(negedge clk);
    check("a5_dv_e1", 32'(tx_dv), 32'd0);
    @(negedge clk);
    check("a5_dv_e2", 32'(tx_dv), 32'd1);
    check("a5_byte", 32'(tx_byte), 32'hA5);
    check("a5_popped", 32'(count), 32'd0);
    @(negedge clk);
    check("a5_dv_e3", 32'(tx_dv), 32'd0);
    check("a5_hold", 32'(tx_byte), 32'hA5);
    wait_rx(base + 1, 200, "a5_rx_timeout");
    check("a5_frame", frame_at(base), 32'h34A);
    repeat (8) @(negedge clk);
    check("a5_empty", 32'(empty), 32'd1);
    check("a5_dvcnt", 32'(dv_count - dvb), 32'd1);

    // Burst 01,02,03 on consecutive cycles
    base = rx_q.size();
    dvb  = dv_count;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h01;
    @(negedge clk); wr_data = 8'h02;
    @(negedge clk); wr_data = 8'h03;
    @(negedge clk); wr_en = 1'b0;
    wait_rx(base + 3, 600, "burst_rx_timeout");
    repeat (8) @(negedge clk);
    check("burst_b0", rx_at(base), 32'h01);
    check("burst_b1", rx_at(base + 1), 32'h02);
    check("burst_b2", rx_at(base + 2), 32'h03);
    check("burst_dvcnt", 32'(dv_count - dvb), 32'd3);
    check("burst_order", 32'(order_err), 32'd0);

    // Overflow with the transmitter held busy
    base = rx_q.size();
    @(negedge clk); hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'hB0 + i);
      @(negedge clk);
      if (i == 3) begin
        check("ovf_full4", 32'(full), 32'd1);
        check("ovf_cnt4", 32'(count), 32'd4);
        check("ovf_clear4", 32'(overflow), 32'd0);
      end
      if (i == 4) begin
        check("ovf_set5", 32'(overflow), 32'd1);
        check("ovf_cnt5", 32'(count), 32'd4);
      end
    end
    wr_en = 1'b0;
    hold_busy = 1'b0;
    wait_rx(base + 4, 600, "ovf_rx_timeout");
    repeat (100) @(negedge clk);
    check("ovf_nrx", 32'(rx_q.size() - base), 32'd4);
    check("ovf_b0", rx_at(base), 32'hB0);
    check("ovf_b3", rx_at(base + 3), 32'hB3);
    check("ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("ovf_rst_clr", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full FIFO, write 55 during the LAUNCH cycle
    base = rx_q.size();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'hC0 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    hold_busy = 1'b0;
    check("sim_full", 32'(full), 32'd1);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    check("sim_cnt", 32'(count), 32'd4);
    check("sim_ovf", 32'(overflow), 32'd0);
    check("sim_dv", 32'(tx_dv), 32'd1);
    check("sim_byte", 32'(tx_byte), 32'hC0);
    wait_rx(base + 5, 800, "sim_rx_timeout");
    check("sim_b1", rx_at(base + 1), 32'hC1);
    check("sim_b3", rx_at(base + 3), 32'hC3);
    check("sim_last", rx_at(base + 4), 32'h55);
    check("sim_ovf_end", 32'(overflow), 32'd0);
    repeat (8) @(negedge clk);

    // Reset during WAIT_DONE with bytes queued; writes under reset ignored
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hD0;
    @(negedge clk); wr_data = 8'hD1;
    @(negedge clk); wr_data = 8'hD2;
    @(negedge clk); wr_en = 1'b0;
    nw = 0;
    while (!tx_done && nw < 200) begin
      @(negedge clk);
      nw++;
    end
    check("mid_done_seen", 32'(tx_done), 32'd1);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    #1;
    check("mid_cnt", 32'(count), 32'd0);
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_dv", 32'(tx_dv), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    dvb = dv_count;
    repeat (150) @(negedge clk);
    check("mid_no_launch", 32'(dv_count - dvb), 32'd0);
    check("mid_empty_end", 32'(empty), 32'd1);

    // Wrap-around: 10 bytes through a 4-deep FIFO
    base = rx_q.size();
    mx = 0;
    nw = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (int'(count) > mx) mx = int'(count);
      wr_en = (nw < 10) && !full;
      if (wr_en) begin
        wr_data = 8'(8'h10 + nw);
        nw++;
      end
      if (nw == 10 && rx_q.size() >= base + 10) break;
    end
    wr_en = 1'b0;
    check("wrap_written", 32'(nw), 32'd10);
    check("wrap_nrx", 32'(rx_q.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("wrap_b%0d", i), rx_at(base + i), 32'(8'h10 + i));
    end
    check("wrap_cnt_le4", 32'(mx <= 4), 32'd1);

    check("dv_single_cycle", 32'(wide_err), 32'd0);
    check("dv_after_done", 32'(order_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
